i2c_target_regs: RTL and testbench

Synthesizable I2C target (responder) with a small byte-addressed register file. It is the bus-side counterpart to the I2C controllers inside `sonata_system`. In Verilator top levels it replaces a DPI device model so controller firmware and RTL are exercised against cycle-accurate target behaviour. It oversamples open-drain SCL/SDA on `clk_i` and drives SDA low only for ACKs and read data.

---
 rtl/i2c_target_pkg.sv | 23 ++
 rtl/i2c_target_sync.sv | 70 +++++++
 rtl/i2c_target_regs.sv | 264 ++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target register block.
//   i2c_target_state_e : protocol state of the byte engine
//   I2cByteW           : bits per I2C byte
//   FilterLen          : samples needed to accept a level change when the
//                        optional glitch filter (I2C_TARGET_GLITCH_FILTER_EN)
//                        is compiled in
package i2c_target_pkg;

  localparam int I2cByteW  = 8;
  localparam int FilterLen = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_target_state_e;

endpackage

// File: rtl/i2c_target_sync.sv
// Input conditioning for one open-drain I2C line.
// A 2-flop synchronizer feeds an optional persistence filter, followed by
// edge detection against the last accepted level.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (3-sample filter).
// Ports:
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset (line assumed idle high)
//   line   : raw bus level
//   level  : conditioned level (valid in the same cycle as rise/fall)
//   rise   : one-cycle strobe, conditioned level went 0 -> 1
//   fall   : one-cycle strobe, conditioned level went 1 -> 0
module i2c_target_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);
  import i2c_target_pkg::*;

  logic [1:0] sync_reg;
  logic       level_reg;
  logic       level_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg  <= 2'b11;
      level_reg <= 1'b1;
    end else begin
      sync_reg  <= {sync_reg[0], line};
      level_reg <= level_next;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // History of the previous FilterLen-1 synchronized samples; together with
  // the current sample a level is accepted only when all agree.
  logic [FilterLen-2:0] hist_reg;
  logic [FilterLen-1:0] window;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_reg <= '1;
    end else begin
      hist_reg <= {hist_reg[FilterLen-3:0], sync_reg[1]};
    end
  end

  assign window = {hist_reg, sync_reg[1]};

  always_comb begin
    level_next = level_reg;
    if (&window) begin
      level_next = 1'b1;
    end else if (~|window) begin
      level_next = 1'b0;
    end
  end
`else
  assign level_next = sync_reg[1];
`endif

  // Edges are reported combinationally from the accepted level so detection
  // lands in the same cycle the new level becomes valid.
  assign level = level_next;
  assign rise  = level_next & ~level_reg;
  assign fall  = ~level_next & level_reg;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-addressed register file.
// Responds to TargetAddr; the first written byte sets the register pointer,
// later written bytes store at the pointer and auto-increment it; reads
// return regs[ptr] with auto-increment. No clock stretching.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (see i2c_target_sync).
// Ports:
//   clk_i, rst_ni       : sampling clock, asynchronous active-low reset
//   scl_i, sda_i        : resolved bus levels
//   sda_o               : 1 = release, 0 = pull low
//   scl_o               : tied high
//   reg_we_i/addr/wdata : local register write port (wins over bus writes)
//   reg_rdata_o         : combinational regs[reg_addr_i]
//   start_o, stop_o     : one-cycle pulses on START/repeated START and STOP
//   bus_wr_o            : one-cycle pulse when a bus write commits a register
module i2c_target_regs #(
  parameter logic [6:0] TargetAddr = 7'h50,
  parameter int         NumRegs    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_o,
  output logic                       scl_o,
  input  logic                       reg_we_i,
  input  logic [$clog2(NumRegs)-1:0] reg_addr_i,
  input  logic [7:0]                 reg_wdata_i,
  output logic [7:0]                 reg_rdata_o,
  output logic                       start_o,
  output logic                       stop_o,
  output logic                       bus_wr_o
);
  import i2c_target_pkg::*;

  localparam int PtrW = $clog2(NumRegs);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_target_sync u_scl_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .line  (scl_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_target_sync u_sda_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .line  (sda_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;

  i2c_target_state_e   state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [I2cByteW-1:0] shift_reg, shift_next;
  logic [PtrW-1:0]     ptr_reg, ptr_next;
  logic                rw_reg, rw_next;
  logic                first_reg, first_next;
  logic                ack_reg, ack_next;       // ACK low phase in progress
  logic                sda_reg, sda_next;
  logic                start_reg, stop_reg, bus_wr_reg, bus_wr_next;

  logic [I2cByteW-1:0] regs [NumRegs];
  logic [I2cByteW-1:0] shift_in;
  logic [I2cByteW-1:0] rd_byte, rd_byte_inc;
  logic [PtrW-1:0]     ptr_inc;
  logic                bus_we;

  assign shift_in    = {shift_reg[I2cByteW-2:0], sda_lvl};
  assign ptr_inc     = ptr_reg + 1'b1;
  assign rd_byte     = regs[ptr_reg];
  assign rd_byte_inc = regs[ptr_inc];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    ptr_next    = ptr_reg;
    rw_next     = rw_reg;
    first_next  = first_reg;
    ack_next    = ack_reg;
    sda_next    = sda_reg;
    bus_wr_next = 1'b0;
    bus_we      = 1'b0;

    if (start_det) begin
      state_next = ADDR;
      cnt_next   = 4'd0;
      sda_next   = 1'b1;
      ack_next   = 1'b0;
    end else if (stop_det) begin
      state_next = IDLE;
      sda_next   = 1'b1;
      ack_next   = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE, IGNORE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_next = shift_in;
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              if (shift_in[7:1] == TargetAddr) begin
                state_next = ADDR_ACK;
                rw_next    = shift_in[0];
                ack_next   = 1'b0;
              end else begin
                state_next = IGNORE;
              end
            end
          end
        end

        // The first fall starts the ACK low phase; the second fall ends it
        // and, for reads, is also the fall on which the MSB must appear.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_reg) begin
              sda_next = 1'b0;
              ack_next = 1'b1;
            end else begin
              ack_next = 1'b0;
              if (rw_reg) begin
                state_next = RD_DATA;
                sda_next   = rd_byte[7];
                shift_next = {rd_byte[6:0], 1'b0};
                cnt_next   = 4'd1;
              end else begin
                state_next = WR_DATA;
                sda_next   = 1'b1;
                cnt_next   = 4'd0;
                first_next = 1'b1;
              end
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_next = shift_in;
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              state_next = WR_ACK;
              ack_next   = 1'b0;
              if (first_reg) begin
                ptr_next = shift_in[PtrW-1:0];
              end else begin
                bus_we      = 1'b1;
                bus_wr_next = 1'b1;
                ptr_next    = ptr_inc;
              end
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_reg) begin
              sda_next = 1'b0;
              ack_next = 1'b1;
            end else begin
              ack_next   = 1'b0;
              sda_next   = 1'b1;
              state_next = WR_DATA;
              cnt_next   = 4'd0;
              first_next = 1'b0;
            end
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_reg == 4'd8) begin
              sda_next   = 1'b1;
              state_next = RD_ACK;
            end else begin
              sda_next   = shift_reg[7];
              shift_next = {shift_reg[6:0], 1'b0};
              cnt_next   = cnt_reg + 4'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            ptr_next = ptr_inc;
            if (!sda_lvl) begin
              state_next = RD_DATA;
              shift_next = rd_byte_inc;
              cnt_next   = 4'd0;
            end else begin
              state_next = IGNORE;
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      shift_reg  <= '0;
      ptr_reg    <= '0;
      rw_reg     <= 1'b0;
      first_reg  <= 1'b0;
      ack_reg    <= 1'b0;
      sda_reg    <= 1'b1;
      start_reg  <= 1'b0;
      stop_reg   <= 1'b0;
      bus_wr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      ptr_reg    <= ptr_next;
      rw_reg     <= rw_next;
      first_reg  <= first_next;
      ack_reg    <= ack_next;
      sda_reg    <= sda_next;
      start_reg  <= start_det;
      stop_reg   <= stop_det;
      bus_wr_reg <= bus_wr_next;
    end
  end

  // Register file; a local write to the same index overrides a bus write.
  for (genvar gi = 0; gi < NumRegs; gi++) begin : g_regs
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        regs[gi] <= '0;
      end else if (reg_we_i && (reg_addr_i == PtrW'(gi))) begin
        regs[gi] <= reg_wdata_i;
      end else if (bus_we && (ptr_reg == PtrW'(gi))) begin
        regs[gi] <= shift_in;
      end
    end
  end

  // A START can only be seen while we are not holding SDA low for a full
  // cycle, but releasing combinationally keeps the bus free on the exact
  // detection cycle.
  assign sda_o       = sda_reg | start_det;
  assign scl_o       = 1'b1;
  assign reg_rdata_o = regs[reg_addr_i];
  assign start_o     = start_reg;
  assign stop_o      = stop_reg;
  assign bus_wr_o    = bus_wr_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic       scl_tb = 1'b1;
  logic       sda_tb = 1'b1;
  logic       scl_i, sda_i, sda_o, scl_o;
  logic       reg_we_i = 1'b0;
  logic [3:0] reg_addr_i = 4'd0;
  logic [7:0] reg_wdata_i = 8'd0;
  logic [7:0] reg_rdata_o;
  logic       start_o, stop_o, bus_wr_o;

  assign scl_i = scl_tb & scl_o;
  assign sda_i = sda_tb & sda_o;

  always #5 clk_i = ~clk_i;

  i2c_target_regs #(.TargetAddr(7'h50), .NumRegs(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_o),
    .scl_o      (scl_o),
    .reg_we_i   (reg_we_i),
    .reg_addr_i (reg_addr_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_rdata_o(reg_rdata_o),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .bus_wr_o   (bus_wr_o)
  );

  int compared   = 0;
  int mismatched = 0;
  int n_start = 0, n_stop = 0, n_wr = 0, n_low = 0;

  always @(posedge clk_i) begin
    if (start_o) n_start <= n_start + 1;
    if (stop_o) n_stop <= n_stop + 1;
    if (bus_wr_o) n_wr <= n_wr + 1;
    if (!sda_o) n_low <= n_low + 1;
  end

  // Reference model: register contents and pointer as the I2C transactions
  // describe them.
  logic [7:0] m_regs [16];
  int         m_ptr = 0;
  logic [7:0] buf_data [4];
  logic [7:0] rd_buf [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk_i);
  endtask

  task automatic bus_start();
    if (!scl_tb) begin
      sda_tb = 1'b1; qwait();
      scl_tb = 1'b1; qwait();
    end
    sda_tb = 1'b0; qwait();
    scl_tb = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    sda_tb = 1'b0; qwait();
    scl_tb = 1'b1; qwait();
    sda_tb = 1'b1; qwait();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_tb = b; qwait();
    scl_tb = 1'b1; qwait();
    if (glitch) begin
      scl_tb = 1'b0;
      @(negedge clk_i);
      scl_tb = 1'b1;
    end
    qwait();
    scl_tb = 1'b0; qwait();
  endtask

  task automatic recv_bit(output logic b);
    sda_tb = 1'b1; qwait();
    scl_tb = 1'b1; qwait();
    b = sda_i; qwait();
    scl_tb = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, input int glitch_bit);
    for (int i = 7; i >= 0; i--) send_bit(d[i], (7 - i) == glitch_bit);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack, 1'b0);
  endtask

  task automatic local_write(input logic [3:0] a, input logic [7:0] d);
    reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    @(negedge clk_i);
    reg_we_i = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic local_check(input string tag, input logic [3:0] a);
    reg_addr_i = a;
    #1;
    check($sformatf("%s_r%0d", tag, a), reg_rdata_o, m_regs[a]);
  endtask

  task automatic scan_regs(input string tag);
    for (int a = 0; a < 16; a++) local_check(tag, 4'(a));
  endtask

  task automatic bus_write(input string tag, input logic [7:0] p, input int n);
    logic ack;
    int   wr0;
    wr0 = n_wr;
    bus_start();
    write_byte(8'hA0, ack, -1); check({tag, "_addr_ack"}, ack, 0);
    write_byte(p, ack, -1);     check({tag, "_ptr_ack"}, ack, 0);
    m_ptr = p % 16;
    for (int i = 0; i < n; i++) begin
      write_byte(buf_data[i], ack, -1);
      check($sformatf("%s_data_ack%0d", tag, i), ack, 0);
      m_regs[m_ptr] = buf_data[i];
      m_ptr = (m_ptr + 1) % 16;
    end
    bus_stop();
    check({tag, "_buswr_cnt"}, n_wr - wr0, n);
  endtask

  task automatic bus_read(input string tag, input bit set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hA0, ack, -1); check({tag, "_waddr_ack"}, ack, 0);
      write_byte(p, ack, -1);     check({tag, "_ptr_ack"}, ack, 0);
      m_ptr = p % 16;
      bus_start();
    end
    write_byte(8'hA1, ack, -1); check({tag, "_raddr_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i == n - 1);
      rd_buf[i] = d;
      check($sformatf("%s_rd%0d", tag, i), d, m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % 16;
    end
    bus_stop();
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ack;
    int   c0, c1, c2;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

    // Reset state
    repeat (4) @(negedge clk_i);
    check("rst_sda_o", sda_o, 1);
    check("rst_scl_o", scl_o, 1);
    check("rst_pulses", {start_o, stop_o, bus_wr_o}, 0);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    check("rst_rel_sda_o", sda_o, 1);
    scan_regs("rst");

    // Write burst
    c0 = n_start; c1 = n_stop;
    buf_data[0] = 8'hA5; buf_data[1] = 8'h5A;
    bus_write("wburst", 8'h03, 2);
    check("wburst_start_cnt", n_start - c0, 1);
    check("wburst_stop_cnt", n_stop - c1, 1);
    reg_addr_i = 4'd3; #1; check("wburst_r3", reg_rdata_o, 8'hA5);
    reg_addr_i = 4'd4; #1; check("wburst_r4", reg_rdata_o, 8'h5A);

    // Read with wrap
    local_write(4'd15, 8'h11);
    local_write(4'd0, 8'h22);
    bus_read("wrap", 1'b1, 8'h0F, 2);
    check("wrap_byte0", rd_buf[0], 8'h11);
    check("wrap_byte1", rd_buf[1], 8'h22);
    bus_read("wrap_ptr1", 1'b0, 8'h00, 1);  // ptr must now be 1

    // Address mismatch
    c0 = n_low;
    bus_start();
    write_byte(8'hA2, ack, -1); check("miss_addr_nack", ack, 1);
    write_byte(8'h00, ack, -1); check("miss_data_nack", ack, 1);
    bus_stop();
    check("miss_sda_low_cycles", n_low - c0, 0);
    scan_regs("miss");

    // Aborted byte
    c2 = n_wr;
    bus_start();
    write_byte(8'hA0, ack, -1); check("abort_addr_ack", ack, 0);
    write_byte(8'h02, ack, -1); check("abort_ptr_ack", ack, 0);
    m_ptr = 2;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    bus_stop();
    check("abort_buswr_cnt", n_wr - c2, 0);
    local_check("abort", 4'd2);
    buf_data[0] = 8'h7E;
    bus_write("abort_follow", 8'h02, 1);
    reg_addr_i = 4'd2; #1; check("abort_follow_r2", reg_rdata_o, 8'h7E);

    // Reset mid-read while the target drives a 0 (regs[0] = 0x22, MSB 0)
    bus_start();
    write_byte(8'hA0, ack, -1); check("rstrd_waddr_ack", ack, 0);
    write_byte(8'h00, ack, -1); check("rstrd_ptr_ack", ack, 0);
    bus_start();
    write_byte(8'hA1, ack, -1); check("rstrd_raddr_ack", ack, 0);
    check("rstrd_sda_driven_low", sda_o, 0);
    #1 rst_ni = 1'b0;
    #1 check("rstrd_sda_async_release", sda_o, 1);
    scl_tb = 1'b1; sda_tb = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    qwait();
    bus_read("rstrd_after", 1'b0, 8'h00, 1);
    check("rstrd_after_byte", rd_buf[0], 8'h00);

    // Glitch: 1-cycle low pulse on SCL during bit 3 of 0x96
    c2 = n_wr;
    bus_start();
    write_byte(8'hA0, ack, -1); check("glitch_addr_ack", ack, 0);
    write_byte(8'h05, ack, -1); check("glitch_ptr_ack", ack, 0);
    write_byte(8'h96, ack, 3);
    bus_stop();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    m_regs[5] = 8'h96;
`else
    m_regs[5] = 8'h9B;  // bit 3 sampled twice: 1,0,0,1,1,0,1,1
`endif
    m_ptr = 6;
    check("glitch_buswr_cnt", n_wr - c2, 1);
    local_check("glitch", 4'd5);

    // Randomized traffic against the model
    for (int it = 0; it < 10; it++) begin
      int op, n;
      logic [7:0] p;
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 4);
      p  = 8'($urandom_range(0, 255));
      if (op == 0) begin
        for (int i = 0; i < n; i++) buf_data[i] = 8'($urandom);
        bus_write($sformatf("rnd%0d_w", it), p, n);
      end else if (op == 1) begin
        bus_read($sformatf("rnd%0d_r", it), 1'($urandom_range(0, 1)), p, n);
      end else begin
        local_write(4'($urandom_range(0, 15)), 8'($urandom));
      end
    end
    scan_regs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
